// File: rtl/vga_vmem_arbiter_pkg.sv
// vga_pkg: shared types and defaults for the video-memory arbiter.
//   MEM_LAT_DEF / SW_DEF : default memory latency and wait-counter width
//   AW_DEF / DW_DEF      : address/data widths baked into the buffer entry type
//   buf_state_t          : host buffer occupancy (EMPTY / FULL)
//   host_entry_t         : buffered host request {we, addr, wdata}
//   rd_tag_t             : read-return tag {d = display, h = host}
package vga_pkg;

  localparam int AW_DEF      = 12;
  localparam int DW_DEF      = 8;
  localparam int MEM_LAT_DEF = 1;
  localparam int SW_DEF      = 16;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  // The entry carries the default widths; the arbiter is built with AW/DW
  // equal to these.
  typedef struct packed {
    logic              we;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } host_entry_t;

  typedef struct packed {
    logic d;
    logic h;
  } rd_tag_t;

endpackage

// File: rtl/vga_vmem_arbiter_if.sv
// vga_vmem_arbiter_if: host-side valid/ready request bus plus read return.
//   host_valid/host_we/host_addr/host_wdata : request from host (master)
//   host_ready                              : request accepted when valid && ready
//   host_rvalid/host_rdata                  : read data return to host
// Modports: master = host bridge, slave = arbiter.
interface vga_vmem_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 8
);
  logic          host_valid;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ready;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;

  modport master (
    output host_valid, host_we, host_addr, host_wdata,
    input  host_ready, host_rvalid, host_rdata
  );

  modport slave (
    input  host_valid, host_we, host_addr, host_wdata,
    output host_ready, host_rvalid, host_rdata
  );
endinterface

// File: rtl/vga_vmem_arbiter_rd_tag_pipe.sv
// vga_rd_tag_pipe: DEPTH-stage shift register of read-return tags, aligned
// with the memory read latency so the tag leaves the last stage in the same
// cycle the read data appears.
//   clk     : clock
//   resetn  : synchronous active-low clear of all stages
//   tag_in  : tag for the access issued this cycle
//   tag_out : tag whose read data is on the memory bus this cycle
module vga_rd_tag_pipe
  import vga_pkg::*;
#(
  parameter int DEPTH = MEM_LAT_DEF
) (
  input  logic    clk,
  input  logic    resetn,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage_reg  [DEPTH];
  rd_tag_t stage_next [DEPTH];

  assign stage_next[0] = tag_in;

  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_shift
    assign stage_next[gi] = stage_reg[gi-1];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg <= stage_next;
    end
  end

  assign tag_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/vga_vmem_arbiter.sv
// vga_vmem_arbiter: shares one single-port synchronous video RAM between the
// display fetch path (strict priority, never stalled) and a host port that is
// buffered in a one-entry register and issued in display-free cycles.
//   clk, resetn               : clock, synchronous active-low reset
//   disp_req/disp_addr        : display read request this cycle
//   disp_rvalid/disp_rdata    : display read return, MEM_LAT cycles later
//   host (slave modport)      : host valid/ready requests and read return
//   mem_en/we/addr/wdata      : memory access issued this cycle
//   mem_rdata                 : memory read data, MEM_LAT cycles after a read
//   stat_clr                  : clear the host wait statistic
//   host_wait_cnt             : saturating count of cycles the buffered host
//                               request lost arbitration to the display
module vga_vmem_arbiter
  import vga_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int SW      = SW_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             disp_req,
  input  logic [AW-1:0]    disp_addr,
  output logic             disp_rvalid,
  output logic [DW-1:0]    disp_rdata,
  vga_vmem_arbiter_if.slave host,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  input  logic             stat_clr,
  output logic [SW-1:0]    host_wait_cnt
);

  localparam logic [SW-1:0] CNT_ONE = SW'(1);
  localparam logic [SW-1:0] CNT_MAX = '1;

  buf_state_t  state_reg, state_next;
  host_entry_t entry_reg, entry_next;
  logic        host_issue;
  logic        accept;
  logic        blocked;
  logic [SW-1:0] wait_reg;
  rd_tag_t     tag_in, tag_out;

  // The buffer can take a new request in the same cycle its current one is
  // issued, which is what gives one host request per cycle when display idles.
  assign host_issue = (state_reg == BUF_FULL) && !disp_req;
  assign accept     = host.host_valid && host.host_ready;
  assign blocked    = (state_reg == BUF_FULL) && disp_req;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= BUF_EMPTY;
      entry_reg <= '0;
    end else begin
      state_reg <= state_next;
      entry_reg <= entry_next;
    end
  end

  // Next-state logic: an accept always (re)loads the entry, so a simultaneous
  // issue + accept keeps the buffer FULL with the newer request.
  always_comb begin
    state_next = state_reg;
    entry_next = entry_reg;
    if (accept) begin
      state_next = BUF_FULL;
      entry_next = '{we: host.host_we, addr: host.host_addr, wdata: host.host_wdata};
    end else if (host_issue) begin
      state_next = BUF_EMPTY;
    end
  end

  // Output logic: handshake and memory arbitration
  always_comb begin
    host.host_ready = (state_reg == BUF_EMPTY) || host_issue;
    mem_en          = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = disp_addr;
    mem_wdata       = entry_reg.wdata;
    if (disp_req) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (state_reg == BUF_FULL) begin
      mem_en   = 1'b1;
      mem_we   = entry_reg.we;
      mem_addr = entry_reg.addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wait_reg <= '0;
    end else if (stat_clr) begin
      wait_reg <= '0;
    end else if (blocked && (wait_reg != CNT_MAX)) begin
      wait_reg <= wait_reg + CNT_ONE;
    end
  end

  assign host_wait_cnt = wait_reg;

  // Host writes return nothing, so only host reads are tagged.
  assign tag_in = '{d: disp_req, h: host_issue && !entry_reg.we};

  vga_rd_tag_pipe #(
    .DEPTH(MEM_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .resetn  (resetn),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign disp_rvalid      = tag_out.d;
  assign disp_rdata       = mem_rdata;
  assign host.host_rvalid = tag_out.h;
  assign host.host_rdata  = mem_rdata;

endmodule

// File: tb/tb_vga_vmem_arbiter.sv
// Bench for vga_vmem_arbiter: two builds (MEM_LAT=1/SW=16 and MEM_LAT=3/SW=4)
// share one directed stimulus. Each build has its own RAM model and a
// queue-based reference model checked every cycle, plus literal pins.
module tb_vga_vmem_arbiter;

  typedef struct {
    int         due;
    logic [7:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        disp_req;
  logic [11:0] disp_addr;
  logic        host_valid;
  logic        host_we;
  logic [11:0] host_addr;
  logic [7:0]  host_wdata;
  logic        stat_clr;
  logic        run_chk = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;

  logic        rdy_o  [2];
  logic        men_o  [2];
  logic        mwe_o  [2];
  logic [11:0] maddr_o[2];
  logic [7:0]  mwd_o  [2];
  logic        drv_o  [2];
  logic [7:0]  drd_o  [2];
  logic        hrv_o  [2];
  logic [7:0]  hrd_o  [2];
  logic [15:0] wcnt_o [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int cfg, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cfg%0d cyc=%0d actual=0x%0h required=0x%0h", name, cfg, cyc, act, exp);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int LAT  = (gi == 0) ? 1 : 3;
    localparam int SW_G = (gi == 0) ? 16 : 4;
    localparam int WMAX = (1 << SW_G) - 1;

    vga_vmem_arbiter_if #(.AW(12), .DW(8)) hif ();
    logic [SW_G-1:0] wcnt;
    logic [7:0]      mrd;
    logic [7:0]      ram   [4096];
    logic [7:0]      rpipe [LAT];

    assign hif.host_valid = host_valid;
    assign hif.host_we    = host_we;
    assign hif.host_addr  = host_addr;
    assign hif.host_wdata = host_wdata;
    assign rdy_o[gi]  = hif.host_ready;
    assign hrv_o[gi]  = hif.host_rvalid;
    assign hrd_o[gi]  = hif.host_rdata;
    assign wcnt_o[gi] = 16'(wcnt);

    vga_vmem_arbiter #(.AW(12), .DW(8), .MEM_LAT(LAT), .SW(SW_G)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .disp_req      (disp_req),
      .disp_addr     (disp_addr),
      .disp_rvalid   (drv_o[gi]),
      .disp_rdata    (drd_o[gi]),
      .host          (hif),
      .mem_en        (men_o[gi]),
      .mem_we        (mwe_o[gi]),
      .mem_addr      (maddr_o[gi]),
      .mem_wdata     (mwd_o[gi]),
      .mem_rdata     (mrd),
      .stat_clr      (stat_clr),
      .host_wait_cnt (wcnt)
    );

    // Single-port synchronous RAM with LAT-cycle read latency.
    initial begin
      for (int i = 0; i < 4096; i++) ram[i] = 8'(i * 7 + 3);
      for (int i = 0; i < LAT; i++) rpipe[i] = 8'h00;
    end
    always @(posedge clk) begin
      for (int k = LAT - 1; k > 0; k--) rpipe[k] = rpipe[k-1];
      if (men_o[gi] && !mwe_o[gi]) rpipe[0] = ram[maddr_o[gi]];
      if (men_o[gi] && mwe_o[gi]) ram[maddr_o[gi]] = mwd_o[gi];
    end
    assign mrd = rpipe[LAT-1];

    // Reference model: expected memory image, buffer contents and response
    // queues stamped with the cycle their data must appear.
    logic [7:0]  shadow [4096];
    logic        full_m = 1'b0;
    logic        bwe_m  = 1'b0;
    logic [11:0] baddr_m = 12'h000;
    logic [7:0]  bwd_m   = 8'h00;
    int          wcnt_m  = 0;
    resp_t       dq[$];
    resp_t       hq[$];

    initial for (int i = 0; i < 4096; i++) shadow[i] = 8'(i * 7 + 3);

    always @(posedge clk) begin
      logic can_take;
      if (!resetn) begin
        full_m = 1'b0;
        wcnt_m = 0;
        dq.delete();
        hq.delete();
      end else begin
        can_take = !full_m || !disp_req;
        if (disp_req) begin
          dq.push_back('{due: cyc + LAT, data: shadow[disp_addr]});
        end else if (full_m) begin
          if (bwe_m) shadow[baddr_m] = bwd_m;
          else hq.push_back('{due: cyc + LAT, data: shadow[baddr_m]});
        end
        if (stat_clr) wcnt_m = 0;
        else if (full_m && disp_req && wcnt_m < WMAX) wcnt_m++;
        if (host_valid && can_take) begin
          full_m  = 1'b1;
          bwe_m   = host_we;
          baddr_m = host_addr;
          bwd_m   = host_wdata;
          if (gi == 0) $display("cyc=%0d host %s addr=%03h wdata=%02h", cyc, host_we ? "wr" : "rd", host_addr, host_wdata);
        end else if (full_m && !disp_req) begin
          full_m = 1'b0;
        end
      end
    end

    always @(negedge clk) begin
      logic exp_en, exp_hw, exp_dv, exp_hv;
      if (run_chk && resetn) begin
        exp_en = disp_req || full_m;
        exp_hw = !disp_req && full_m && bwe_m;
        chk("host_ready", gi, 32'(rdy_o[gi]), 32'(!full_m || !disp_req));
        chk("mem_en", gi, 32'(men_o[gi]), 32'(exp_en));
        if (exp_en) begin
          chk("mem_we", gi, 32'(mwe_o[gi]), 32'(exp_hw));
          chk("mem_addr", gi, 32'(maddr_o[gi]), 32'(disp_req ? disp_addr : baddr_m));
          if (exp_hw) chk("mem_wdata", gi, 32'(mwd_o[gi]), 32'(bwd_m));
        end
        exp_dv = (dq.size() > 0) && (dq[0].due == cyc);
        chk("disp_rvalid", gi, 32'(drv_o[gi]), 32'(exp_dv));
        if (exp_dv) begin
          chk("disp_rdata", gi, 32'(drd_o[gi]), 32'(dq[0].data));
          void'(dq.pop_front());
        end
        exp_hv = (hq.size() > 0) && (hq[0].due == cyc);
        chk("host_rvalid", gi, 32'(hrv_o[gi]), 32'(exp_hv));
        if (exp_hv) begin
          chk("host_rdata", gi, 32'(hrd_o[gi]), 32'(hq[0].data));
          void'(hq.pop_front());
        end
        chk("wait_cnt", gi, 32'(wcnt_o[gi]), 32'(wcnt_m));
        chk("one_valid", gi, 32'(drv_o[gi] && hrv_o[gi]), 32'(0));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    disp_req   = 1'b0;
    host_valid = 1'b0;
    host_we    = 1'b0;
    stat_clr   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int   sent;
    int   guard;
    logic tog;
    resetn = 1'b0;
    idle_in();
    disp_addr  = 12'h000;
    host_addr  = 12'h000;
    host_wdata = 8'h00;
    repeat (3) step();
    resetn  = 1'b1;
    run_chk = 1'b1;

    // Reset state
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      chk("rst_ready", c, 32'(rdy_o[c]), 32'(1));
      chk("rst_mem_en", c, 32'(men_o[c]), 32'(0));
      chk("rst_disp_rvalid", c, 32'(drv_o[c]), 32'(0));
      chk("rst_host_rvalid", c, 32'(hrv_o[c]), 32'(0));
      chk("rst_wait_cnt", c, 32'(wcnt_o[c]), 32'(0));
    end
    step();

    // Host write 0x010 <= A5, then read it back
    host_valid = 1'b1; host_we = 1'b1; host_addr = 12'h010; host_wdata = 8'hA5;
    @(negedge clk);
    chk("wr_accept_ready", 0, 32'(rdy_o[0]), 32'(1));
    chk("wr_accept_mem_en", 0, 32'(men_o[0]), 32'(0));
    step();
    host_we = 1'b0;
    @(negedge clk);
    chk("wr_issue_we", 0, 32'(mwe_o[0]), 32'(1));
    chk("wr_issue_addr", 0, 32'(maddr_o[0]), 32'(12'h010));
    chk("wr_issue_wdata", 0, 32'(mwd_o[0]), 32'(8'hA5));
    chk("wr_issue_ready", 0, 32'(rdy_o[0]), 32'(1));
    step();
    host_valid = 1'b0;
    @(negedge clk);
    chk("rd_issue_en", 0, 32'(men_o[0]), 32'(1));
    chk("rd_issue_we", 0, 32'(mwe_o[0]), 32'(0));
    step();
    @(negedge clk);
    chk("rd_rvalid", 0, 32'(hrv_o[0]), 32'(1));
    chk("rd_rdata", 0, 32'(hrd_o[0]), 32'(8'hA5));
    step();

    // 800 display cycles while a host write waits in the buffer
    host_valid = 1'b1; host_we = 1'b1; host_addr = 12'h020; host_wdata = 8'h3C;
    step();
    host_valid = 1'b0;
    for (int k = 0; k < 800; k++) begin
      disp_req  = 1'b1;
      disp_addr = 12'(k);
      if (k == 1) begin
        @(negedge clk);
        chk("burst_disp_rvalid", 0, 32'(drv_o[0]), 32'(1));
        chk("burst_ready", 0, 32'(rdy_o[0]), 32'(0));
      end
      step();
    end
    disp_req = 1'b0;
    host_valid = 1'b1; host_we = 1'b1; host_addr = 12'h021; host_wdata = 8'h77;
    @(negedge clk);
    chk("burst_wait_cnt", 0, 32'(wcnt_o[0]), 32'(800));
    chk("sat_wait_cnt", 1, 32'(wcnt_o[1]), 32'(15));
    chk("burst_host_we", 0, 32'(mwe_o[0]), 32'(1));
    chk("burst_host_addr", 0, 32'(maddr_o[0]), 32'(12'h020));
    step();

    // stat_clr while blocked
    host_valid = 1'b0; disp_req = 1'b1; disp_addr = 12'h300;
    @(negedge clk);
    chk("clr_pre", 0, 32'(wcnt_o[0]), 32'(800));
    step();
    stat_clr = 1'b1;
    @(negedge clk);
    chk("clr_pre2", 0, 32'(wcnt_o[0]), 32'(801));
    step();
    stat_clr = 1'b0;
    @(negedge clk);
    chk("clr_zero", 0, 32'(wcnt_o[0]), 32'(0));
    chk("clr_zero", 1, 32'(wcnt_o[1]), 32'(0));
    step();
    disp_req = 1'b0;
    @(negedge clk);
    chk("clr_recount", 0, 32'(wcnt_o[0]), 32'(1));
    chk("clr_host_addr", 0, 32'(maddr_o[0]), 32'(12'h021));
    step();

    // Alternating display with streaming host reads 0x000..0x00F
    sent = 0; guard = 0; tog = 1'b1;
    while (sent < 16 && guard < 100) begin
      disp_req = tog; disp_addr = 12'h100 + 12'(guard);
      host_valid = 1'b1; host_we = 1'b0; host_addr = 12'(sent);
      @(negedge clk);
      if (rdy_o[0]) sent++;
      tog = !tog;
      guard++;
      step();
    end
    idle_in();
    chk("stream_sent", 0, 32'(sent), 32'(16));
    repeat (5) step();

    // Latency: display 0x123 and host read 0x045 in the same cycle
    disp_req = 1'b1; disp_addr = 12'h123;
    host_valid = 1'b1; host_we = 1'b0; host_addr = 12'h045;
    step();
    idle_in();
    for (int off = 1; off <= 4; off++) begin
      @(negedge clk);
      chk("lat3_disp_rvalid", 1, 32'(drv_o[1]), 32'(off == 3));
      chk("lat3_host_rvalid", 1, 32'(hrv_o[1]), 32'(off == 4));
      if (off == 3) chk("lat3_disp_rdata", 1, 32'(drd_o[1]), 32'(8'hF8));
      if (off == 4) chk("lat3_host_rdata", 1, 32'(hrd_o[1]), 32'(8'hE6));
      if (off == 1) chk("lat1_disp_rvalid", 0, 32'(drv_o[0]), 32'(1));
      if (off == 2) chk("lat1_host_rdata", 0, 32'(hrd_o[0]), 32'(8'hE6));
      step();
    end

    // Reset with reads in flight and the buffer FULL
    disp_req = 1'b1; disp_addr = 12'h200;
    host_valid = 1'b1; host_we = 1'b0; host_addr = 12'h001;
    step();
    disp_req = 1'b0; host_addr = 12'h002;
    step();
    idle_in();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        chk("mid_rst_ready", c, 32'(rdy_o[c]), 32'(1));
        chk("mid_rst_mem_en", c, 32'(men_o[c]), 32'(0));
        chk("mid_rst_disp_rvalid", c, 32'(drv_o[c]), 32'(0));
        chk("mid_rst_host_rvalid", c, 32'(hrv_o[c]), 32'(0));
      end
      step();
    end

    // Recovery: write then read back
    host_valid = 1'b1; host_we = 1'b1; host_addr = 12'h3FF; host_wdata = 8'h5A;
    step();
    host_we = 1'b0;
    step();
    idle_in();
    repeat (5) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
